// File: rtl/scaled_plane_fetch.sv
`default_nettype none
// ============================================================================
// Module   : scaled_plane_fetch
// Purpose  : Walks a SRC_W x SRC_H source image held in a synchronous ROM and
//            emits a raster-order pixel stream into the write side of a FIFO.
//            Each source pixel is repeated SCALE_X times horizontally and each
//            source line SCALE_Y times vertically. A burst (one source pixel,
//            SCALE_X writes) starts only when the FIFO is below LOW_WATER.
// Ports    : clock, reset      - clock (FIFO write / ROM clock), sync reset
//            enable            - permits new bursts
//            frame_sync        - pulse, restart at pixel (0,0)
//            rom_data          - ROM read data (ROM_LAT cycles after address)
//            wrusedw, wrfull   - FIFO write-side occupancy and full flag
//            address           - registered ROM address
//            fifo_data, wrreq  - FIFO write data and strobe
//            line_done         - one-cycle pulse after each output line
//            frame_done        - one-cycle pulse after each frame
// Revision : 1.0 - initial release
// ============================================================================
module scaled_plane_fetch #(
    parameter int DATA_W    = 24,
    parameter int SRC_W     = 80,
    parameter int SRC_H     = 60,
    parameter int SCALE_X   = 8,
    parameter int SCALE_Y   = 8,
    parameter int ADDR_W    = 13,
    parameter int USEDW_W   = 10,
    parameter int LOW_WATER = 500,
    parameter int ROM_LAT   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                frame_sync,
    input  logic [DATA_W-1:0]   rom_data,
    input  logic [USEDW_W-1:0]  wrusedw,
    input  logic                wrfull,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W-1:0]   fifo_data,
    output logic                wrreq,
    output logic                line_done,
    output logic                frame_done
);

    // Counter widths; a range of one still needs a 1-bit register.
    localparam int XW  = (SRC_W   > 1) ? $clog2(SRC_W)   : 1;
    localparam int YW  = (SRC_H   > 1) ? $clog2(SRC_H)   : 1;
    localparam int XRW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int YRW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
    localparam int LW  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    localparam logic [XW-1:0]     C_X_LAST    = XW'(SRC_W - 1);
    localparam logic [YW-1:0]     C_Y_LAST    = YW'(SRC_H - 1);
    localparam logic [XRW-1:0]    C_XREP_LAST = XRW'(SCALE_X - 1);
    localparam logic [YRW-1:0]    C_YREP_LAST = YRW'(SCALE_Y - 1);
    localparam logic [LW-1:0]     C_LAT_LAST  = LW'(ROM_LAT - 1);
    localparam logic [ADDR_W-1:0] C_SRC_W     = ADDR_W'(SRC_W);
    localparam logic [31:0]       C_LOW_WATER = 32'(LOW_WATER);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic [XRW-1:0]      r_xrep;
    logic [YRW-1:0]      r_yrep;
    logic [LW-1:0]       r_lat;
    logic [ADDR_W-1:0]   r_line_base;
    logic [ADDR_W-1:0]   r_address;
    logic                r_line_done;
    logic                r_frame_done;

    logic                w_room;
    logic                w_in_write;

    // Compare in 32 bits so LOW_WATER may equal 2**USEDW_W without wrapping.
    assign w_room     = (32'(wrusedw) < C_LOW_WATER);
    assign w_in_write = (r_state == ST_WRITE);

    always_ff @(posedge clock) begin
        // Strobes are single-cycle unless re-armed below.
        r_line_done  <= 1'b0;
        r_frame_done <= 1'b0;
        // Reset and frame_sync clear the same state; an in-flight burst is
        // dropped and no completion strobe is produced.
        if (reset || frame_sync) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_xrep      <= '0;
            r_yrep      <= '0;
            r_lat       <= '0;
            r_line_base <= '0;
            r_address   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_room && !wrfull) begin
                        r_state <= ST_FETCH;
                        r_lat   <= '0;
                    end
                end
                ST_FETCH: begin
                    // Address has been stable since entry; wait out the ROM.
                    if (r_lat == C_LAT_LAST) begin
                        r_state <= ST_WRITE;
                        r_xrep  <= '0;
                    end else begin
                        r_lat <= r_lat + 1'b1;
                    end
                end
                ST_WRITE: begin
                    // A full FIFO only freezes the burst; nothing else stops it.
                    if (!wrfull) begin
                        if (r_xrep == C_XREP_LAST) begin
                            r_xrep  <= '0;
                            r_lat   <= '0;
                            r_state <= (enable && w_room) ? ST_FETCH : ST_IDLE;
                            if (r_x != C_X_LAST) begin
                                r_x       <= r_x + 1'b1;
                                r_address <= r_address + 1'b1;
                            end else begin
                                r_x         <= '0;
                                r_line_done <= 1'b1;
                                if (r_yrep != C_YREP_LAST) begin
                                    // Repeat the same source line.
                                    r_yrep    <= r_yrep + 1'b1;
                                    r_address <= r_line_base;
                                end else if (r_y != C_Y_LAST) begin
                                    r_yrep      <= '0;
                                    r_y         <= r_y + 1'b1;
                                    r_line_base <= r_line_base + C_SRC_W;
                                    r_address   <= r_line_base + C_SRC_W;
                                end else begin
                                    r_yrep       <= '0;
                                    r_y          <= '0;
                                    r_line_base  <= '0;
                                    r_address    <= '0;
                                    r_frame_done <= 1'b1;
                                end
                            end
                        end else begin
                            r_xrep <= r_xrep + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign address    = r_address;
    assign line_done  = r_line_done;
    assign frame_done = r_frame_done;
    assign wrreq      = w_in_write && !wrfull;
    assign fifo_data  = w_in_write ? rom_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_scaled_plane_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_scaled_plane_fetch
// Purpose  : Directed self-checking bench for scaled_plane_fetch. One instance
//            uses default geometry, a second a tiny 4x2 image with 2x3 scaling
//            and a two-cycle ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scaled_plane_fetch;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Default-parameter instance
    logic        reset, enable, frame_sync, wrfull;
    logic [9:0]  wrusedw;
    logic [23:0] rom_q, fifo_data;
    logic [12:0] address;
    logic        wrreq, line_done, frame_done;

    // Small-geometry instance
    logic        s_reset, s_enable, s_frame_sync, s_wrfull;
    logic [9:0]  s_wrusedw;
    logic [23:0] s_rom1, s_rom_q, s_fifo_data;
    logic [2:0]  s_address;
    logic        s_wrreq, s_line_done, s_frame_done;

    scaled_plane_fetch u_dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .frame_sync (frame_sync),
        .rom_data   (rom_q),
        .wrusedw    (wrusedw),
        .wrfull     (wrfull),
        .address    (address),
        .fifo_data  (fifo_data),
        .wrreq      (wrreq),
        .line_done  (line_done),
        .frame_done (frame_done)
    );

    scaled_plane_fetch #(
        .DATA_W(24), .SRC_W(4), .SRC_H(2), .SCALE_X(2), .SCALE_Y(3),
        .ADDR_W(3), .USEDW_W(10), .LOW_WATER(500), .ROM_LAT(2)
    ) u_small (
        .clock      (clock),
        .reset      (s_reset),
        .enable     (s_enable),
        .frame_sync (s_frame_sync),
        .rom_data   (s_rom_q),
        .wrusedw    (s_wrusedw),
        .wrfull     (s_wrfull),
        .address    (s_address),
        .fifo_data  (s_fifo_data),
        .wrreq      (s_wrreq),
        .line_done  (s_line_done),
        .frame_done (s_frame_done)
    );

    function automatic logic [23:0] rom_val(input logic [12:0] a);
        return 24'h5A0000 | {11'd0, a};
    endfunction

    // ROM models: one-cycle and two-cycle synchronous read.
    always @(posedge clock) begin
        rom_q   <= rom_val(address);
        s_rom1  <= rom_val(13'(s_address));
        s_rom_q <= s_rom1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_cnt = 0, ld_cnt = 0, fd_cnt = 0;
    int s_wr_cnt = 0, s_ld_cnt = 0, s_fd_cnt = 0;
    logic [2:0]  s_addr_log [64];
    logic [23:0] s_data_log [64];
    int          s_cyc_log  [64];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and account for this cycle's outputs.
    task automatic step();
        @(negedge clock);
        cyc++;
        if (wrreq)      wr_cnt++;
        if (line_done)  ld_cnt++;
        if (frame_done) fd_cnt++;
        if (s_wrreq) begin
            if (s_wr_cnt < 64) begin
                s_addr_log[s_wr_cnt] = s_address;
                s_data_log[s_wr_cnt] = s_fifo_data;
                s_cyc_log[s_wr_cnt]  = cyc;
            end
            s_wr_cnt++;
        end
        if (s_line_done)  s_ld_cnt++;
        if (s_frame_done) s_fd_cnt++;
    endtask

    task automatic wait_wr(input int target, input int budget);
        int k = 0;
        while (wr_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk("wait_wr", 32'(wr_cnt), 32'(target));
    endtask

    task automatic wait_swr(input int target, input int budget);
        int k = 0;
        while (s_wr_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk("wait_swr", 32'(s_wr_cnt), 32'(target));
    endtask

    initial begin
        logic [16:0] pat;
        logic [23:0] d [17];
        int base, good, hi, bad;

        reset = 1'b1; enable = 1'b1; frame_sync = 1'b0; wrfull = 1'b0; wrusedw = 10'd0;
        s_reset = 1'b1; s_enable = 1'b1; s_frame_sync = 1'b0; s_wrfull = 1'b0; s_wrusedw = 10'd0;

        // ---------------- reset values ----------------
        repeat (5) step();
        chk("rst_addr",  32'(address),    32'd0);
        chk("rst_wrreq", 32'(wrreq),      32'd0);
        chk("rst_data",  32'(fifo_data),  32'd0);
        chk("rst_ld",    32'(line_done),  32'd0);
        chk("rst_fd",    32'(frame_done), 32'd0);
        reset = 1'b0;

        // ---------------- first bursts ----------------
        step();
        chk("lat_fetch", 32'(wrreq), 32'd0);
        for (int i = 0; i < 17; i++) begin
            step();
            pat[16-i] = wrreq;
            d[i]      = fifo_data;
        end
        chk("burst_pat", 32'(pat), 32'h1FEFF);
        chk("d0",  32'(d[0]),  32'(rom_val(13'd0)));
        chk("d7",  32'(d[7]),  32'(rom_val(13'd0)));
        chk("d9",  32'(d[9]),  32'(rom_val(13'd1)));
        chk("d16", 32'(d[16]), 32'(rom_val(13'd1)));

        // ---------------- line repeat / advance ----------------
        wait_wr(640, 1000);
        step();
        chk("l1_ld",   32'(line_done), 32'd1);
        chk("l1_addr", 32'(address),   32'd0);
        chk("l1_ldc",  32'(ld_cnt),    32'd1);
        wait_wr(5120, 7000);
        step();
        chk("y1_addr", 32'(address), 32'd80);
        chk("y1_ldc",  32'(ld_cnt),  32'd8);
        chk("y1_fdc",  32'(fd_cnt),  32'd0);

        // ---------------- threshold ----------------
        wrusedw = 10'd500;
        repeat (20) step();
        base = wr_cnt;
        repeat (20) step();
        chk("thr_hold", 32'(wr_cnt - base), 32'd0);
        chk("thr_cnt",  32'(wr_cnt),        32'd5128);
        chk("thr_addr", 32'(address),       32'd81);
        wrusedw = 10'd499;
        base = wr_cnt;
        step();
        chk("thr_fetch", 32'(wrreq), 32'd0);
        step();
        chk("thr_w1",   32'(wrreq),     32'd1);
        chk("thr_d1",   32'(fifo_data), 32'(rom_val(13'd81)));
        repeat (2) step();
        wrusedw = 10'd600;
        repeat (30) step();
        chk("thr_burst", 32'(wr_cnt - base), 32'd8);
        chk("thr_addr2", 32'(address),       32'd82);
        chk("thr_idle",  32'(wrreq),         32'd0);

        // ---------------- stall ----------------
        wrusedw = 10'd0;
        base = wr_cnt;
        step();
        good = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wrreq && fifo_data == rom_val(13'd82)) good++;
        end
        chk("stl_pre", 32'(good), 32'd4);
        wrfull = 1'b1;
        hi = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wrreq) hi++;
            if (address != 13'd82) bad++;
        end
        wrfull = 1'b0;
        chk("stl_low",  32'(hi),  32'd0);
        chk("stl_addr", 32'(bad), 32'd0);
        good = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wrreq && fifo_data == rom_val(13'd82)) good++;
        end
        chk("stl_post", 32'(good), 32'd4);
        step();
        chk("stl_gap",   32'(wrreq),         32'd0);
        chk("stl_next",  32'(address),       32'd83);
        chk("stl_total", 32'(wr_cnt - base), 32'd8);

        // ---------------- resync at x=37, yrep=3 ----------------
        wait_wr(7339, 3000);
        chk("rs_pre_addr", 32'(address), 32'd117);
        chk("rs_pre_ldc",  32'(ld_cnt),  32'd11);
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("rs_addr",  32'(address),   32'd0);
        chk("rs_wrreq", 32'(wrreq),     32'd0);
        chk("rs_data",  32'(fifo_data), 32'd0);
        step();
        step();
        chk("rs_w1",  32'(wrreq),     32'd1);
        chk("rs_d1",  32'(fifo_data), 32'(rom_val(13'd0)));
        chk("rs_ldc", 32'(ld_cnt),    32'd11);
        chk("rs_fdc", 32'(fd_cnt),    32'd0);
        enable = 1'b0;

        // ---------------- small geometry, ROM_LAT=2 ----------------
        chk("s_rst_addr",  32'(s_address), 32'd0);
        chk("s_rst_wrreq", 32'(s_wrreq),   32'd0);
        s_reset = 1'b0;
        wait_swr(48, 400);
        step();
        chk("s_fd",    32'(s_frame_done), 32'd1);
        chk("s_ld",    32'(s_line_done),  32'd1);
        chk("s_addr0", 32'(s_address),    32'd0);
        chk("s_ldc",   32'(s_ld_cnt),     32'd6);
        chk("s_fdc",   32'(s_fd_cnt),     32'd1);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            int ea;
            ea = ((i / 8) / 3) * 4 + (i % 8) / 2;
            if (s_addr_log[i] != 3'(ea)) bad++;
            if (s_data_log[i] != rom_val(13'(ea))) bad++;
        end
        chk("s_seq",   32'(bad),           32'd0);
        chk("s_a7",    32'(s_addr_log[7]), 32'd3);
        chk("s_a8",    32'(s_addr_log[8]), 32'd0);
        chk("s_a24",   32'(s_addr_log[24]), 32'd4);
        chk("s_a47",   32'(s_addr_log[47]), 32'd7);
        chk("s_rep",   32'(s_cyc_log[1] - s_cyc_log[0]), 32'd1);
        chk("s_period", 32'(s_cyc_log[2] - s_cyc_log[0]), 32'd4);

        // Reset and frame_sync together mid-burst
        wait_swr(51, 100);
        chk("s_pre_sim", 32'(s_address), 32'd1);
        s_reset = 1'b1;
        s_frame_sync = 1'b1;
        step();
        s_frame_sync = 1'b0;
        chk("s_sim_addr",  32'(s_address),    32'd0);
        chk("s_sim_wrreq", 32'(s_wrreq),      32'd0);
        chk("s_sim_data",  32'(s_fifo_data),  32'd0);
        chk("s_sim_ld",    32'(s_line_done),  32'd0);
        chk("s_sim_fd",    32'(s_frame_done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
